// File: rtl/trisbus_pkg.sv
// Shared types and timing constants for the tristate bus read controller.
package trisbus_pkg;

    // Read-side FSM: select source, settle, capture, then a dead turnaround cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        TURN   = 2'd3
    } trisbus_state_t;

    // Timing of one read. The FSM is built for exactly one cycle of each;
    // these name the numbers rather than parameterize them.
    localparam int SETTLE_CYCLES = 1;
    localparam int TURN_CYCLES   = 1;

endpackage

// File: rtl/trisbus_reader.sv
// Read-side controller for a shared tristate data bus. Enables exactly one
// source at a time, waits a settle cycle, captures the bus, and inserts a
// dead cycle before any other source may drive.
module trisbus_reader
    import trisbus_pkg::*;
#(
    parameter  int n    = 16,
    parameter  int NSRC = 4,
    localparam int SW   = $clog2(NSRC)
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Rd_Req,
    input  logic [SW-1:0]   Rd_Sel,
    output logic            Busy,
    output logic [NSRC-1:0] Reg_EN,
    input  logic [n-1:0]    TrisBus,
    output logic [n-1:0]    DataOut,
    output logic            Data_Valid,
    output logic            Sel_Err
);

    // NSRC widened by one bit so an out-of-range select compares cleanly
    localparam logic [SW:0] NSRC_W = (SW+1)'(NSRC);

    trisbus_state_t  r_state;
    trisbus_state_t  w_state_nxt;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   w_sel_nxt;
    logic [NSRC-1:0] r_reg_en;
    logic [NSRC-1:0] w_reg_en_nxt;
    logic [n-1:0]    r_data_out;
    logic            r_data_valid;
    logic            r_sel_err;
    logic            w_capture;
    logic            w_sel_ok;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state; select is latched only on acceptance so later Rd_Sel changes are ignored
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            IDLE: begin
                if (Rd_Req) begin
                    w_state_nxt = DRIVE;
                    w_sel_nxt   = Rd_Sel;
                end
            end
            DRIVE:   w_state_nxt = SAMPLE;
            SAMPLE:  w_state_nxt = TURN;
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode: enables are computed from the next state so Reg_EN is a clean flop;
    // an out-of-range select matches no bit and leaves the bus floating
    always_comb begin
        w_reg_en_nxt = '0;
        w_capture    = (r_state == SAMPLE);
        w_sel_ok     = ({1'b0, r_sel} < NSRC_W);
        if (w_state_nxt == DRIVE || w_state_nxt == SAMPLE) begin
            for (int i = 0; i < NSRC; i++) begin
                w_reg_en_nxt[i] = (w_sel_nxt == i[SW-1:0]);
            end
        end
    end

    // Select latch, enables and capture; reset aborts a read without a pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sel        <= '0;
            r_reg_en     <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_sel        <= w_sel_nxt;
            r_reg_en     <= w_reg_en_nxt;
            r_data_valid <= w_capture;
            r_sel_err    <= w_capture & ~w_sel_ok;
            if (w_capture) r_data_out <= w_sel_ok ? TrisBus : '0;
        end
    end

    assign Busy       = (r_state != IDLE);
    assign Reg_EN     = r_reg_en;
    assign DataOut    = r_data_out;
    assign Data_Valid = r_data_valid;
    assign Sel_Err    = r_sel_err;

endmodule
